// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: RV32I load/store sequencer driving a byte-lane-masked synchronous data memory.
// Rev 1.0 -- initial release.
module load_store_unit #(
  parameter int DMEM_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  data_en,
  output logic [DMEM_WIDTH-1:0] data_addr,
  output logic [3:0]            data_we,
  output logic [31:0]           data_write,
  input  logic [31:0]           data_read
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             accept;
  logic             illegal;
  logic             misaligned;
  logic             wait_done;
  logic [3:0]       we_mask;
  logic [31:0]      lane_data;
  logic [31:0]      shifted;
  logic [31:0]      load_ext;

  // Address bits above the memory window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DMEM_WIDTH+2];

  assign accept    = (state == IDLE) && req_valid;
  assign wait_done = (cnt == CNT_LAST);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    we_mask    = 4'b0000;
    lane_data  = 32'h0;
    if (req_write) begin
      illegal = req_funct3[2] || (req_funct3 == 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        we_mask   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        we_mask   = 4'b0011 << {req_addr[1], 1'b0};
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        we_mask   = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = (illegal || misaligned) ? RESP : ACCESS;
        end
      end
      ACCESS:  state_next = write_q ? RESP : WAIT;
      WAIT:    state_next = wait_done ? RESP : WAIT;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane select and extension of the returned word.
  always_comb begin
    shifted  = data_read >> {off_q, 3'b000};
    load_ext = 32'h0;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      data_en         <= 1'b0;
      data_addr       <= '0;
      data_we         <= 4'b0000;
      data_write      <= 32'h0;
    end else begin
      state      <= state_next;
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      data_en    <= (state_next == ACCESS);
      // Only an accepted, non-faulting store reaches ACCESS with req_write set.
      data_we    <= ((state_next == ACCESS) && req_write) ? we_mask : 4'b0000;

      resp_illegal    <= accept && illegal;
      resp_misaligned <= accept && !illegal && misaligned;
      resp_rdata      <= ((state == WAIT) && wait_done) ? load_ext : 32'h0;

      if (state == ACCESS) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end

      if (accept) begin
        write_q    <= req_write;
        funct3_q   <= req_funct3;
        off_q      <= req_addr[1:0];
        data_addr  <= req_addr[DMEM_WIDTH+1:2];
        data_write <= lane_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: scoreboard bench for load_store_unit (main L=1 DUT plus L=1..4 sweep DUTs).
// Rev 1.0 -- initial release.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic        data_en;
  logic [15:0] data_addr;
  logic [3:0]  data_we;
  logic [31:0] data_write;
  logic [31:0] data_read;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic mon_en;

  logic sw_reset;
  logic sw_valid;
  logic sw_mon;
  logic sw_done;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        w;
  } acc_t;

  resp_t resp_q [$];
  acc_t  acc_q  [$];
  logic [31:0] mem [64];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.DMEM_WIDTH(16), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .data_en(data_en), .data_addr(data_addr), .data_we(data_we),
    .data_write(data_write), .data_read(data_read)
  );

  // Synchronous memory, one cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (data_en) begin
      data_read <= mem[data_addr[5:0]];
      for (int b = 0; b < 4; b++) begin
        if (data_we[b]) mem[data_addr[5:0]][8*b +: 8] = data_write[8*b +: 8];
      end
    end
  end

  always @(negedge clk) begin : mon_main
    resp_t r;
    acc_t  a;
    if (mon_en) begin
      if (resp_valid) begin
        check("resp_pending", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_misaligned", 32'(resp_misaligned), 32'(r.mis));
          check("resp_illegal", 32'(resp_illegal), 32'(r.ill));
          check("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end else begin
        check("resp_idle", resp_rdata | {30'h0, resp_misaligned, resp_illegal}, 32'h0);
      end
      if (data_en) begin
        check("access_pending", 32'(acc_q.size() != 0), 32'd1);
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          check("data_addr", {16'h0, data_addr}, {16'h0, a.addr});
          check("data_we", {28'h0, data_we}, {28'h0, a.we});
          if (a.w) check("data_write", data_write, a.wd);
        end
      end else begin
        check("we_idle", {28'h0, data_we}, 32'h0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic em,
                        input logic ei, input logic [3:0] ewe, input logic [31:0] ewd);
    int n;
    resp_t r;
    acc_t  ac;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    r.rdata = er;
    r.mis   = em;
    r.ill   = ei;
    r.lat   = (em || ei) ? 1 : (w ? 2 : 3);
    r.acc   = cyc;
    resp_q.push_back(r);
    if (!(em || ei)) begin
      ac.addr = a[17:2];
      ac.we   = w ? ewe : 4'b0000;
      ac.wd   = ewd;
      ac.w    = w;
      acc_q.push_back(ac);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int LAT = g + 1;
    localparam logic [31:0] EXP = {8'(8'hC0 + g), 8'h00, 16'h0010};
    logic        ready, resp_valid, mis, ill, en;
    logic [31:0] rdata, wdata, dread;
    logic [15:0] daddr;
    logic [3:0]  we;
    logic [31:0] pipe [LAT];
    int          q [$];
    int          last_acc = -1;
    int          n_acc = 0;
    int          n_resp = 0;

    load_store_unit #(.DMEM_WIDTH(16), .READ_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(sw_reset),
      .req_valid(sw_valid), .req_ready(ready), .req_write(1'b0),
      .req_funct3(3'b010), .req_addr(32'h0000_0040), .req_wdata(32'h0),
      .resp_valid(resp_valid), .resp_rdata(rdata),
      .resp_misaligned(mis), .resp_illegal(ill),
      .data_en(en), .data_addr(daddr), .data_we(we),
      .data_write(wdata), .data_read(dread)
    );

    // Data is only valid in the exact cycle the memory returns it.
    always @(posedge clk) begin
      pipe[0] <= en ? {8'(8'hC0 + g), 8'h00, daddr} : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign dread = pipe[LAT-1];

    always @(negedge clk) begin
      if (sw_mon) begin
        if (resp_valid) begin
          check("sw_pending", 32'(q.size() != 0), 32'd1);
          n_resp++;
          if (q.size() != 0) begin
            check("sw_latency", 32'(cyc), 32'(q.pop_front()));
            check("sw_rdata", rdata, EXP);
          end
        end
        if (sw_valid && ready) begin
          if (last_acc >= 0) check("sw_accept_gap", 32'(cyc - last_acc), 32'(LAT + 3));
          last_acc = cyc;
          n_acc++;
          q.push_back(cyc + 2 + LAT);
        end
      end
    end

    always @(posedge sw_done) begin
      check("sw_drained", 32'(q.size()), 32'd0);
      check("sw_resp_count", 32'(n_resp), 32'(n_acc));
      check("sw_min_accepts", 32'(n_acc >= 5), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b1;  sw_reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mon_en = 1'b0; sw_valid = 1'b0; sw_mon = 1'b0; sw_done = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8] = 32'h80FF_7F01;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_data_en", 32'(data_en), 32'd0);
    check("rst_outputs", resp_rdata | data_write | {12'h0, data_addr, data_we}, 32'h0);
    reset = 1'b0; sw_reset = 1'b0;
    mon_en = 1'b1;

    //     w     f3      addr          wdata         rdata         mis   ill   we       lane data
    do_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        1'b0, 1'b0, 4'b1000, 32'hA5A5_A5A5);
    do_req(1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    do_req(1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'hBEEF_0000, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'h0000_007F, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b000, 32'h0000_0022, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b100, 32'h0000_0023, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'hFFFF_80FF, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b101, 32'h0000_0022, 32'h0,         32'h0000_80FF, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h80FF_7F01, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b001, 32'h0000_0020, 32'h0,         32'h0000_7F01, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b1, 3'b010, 32'h0000_0024, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 4'b1111, 32'h1234_5678);
    do_req(1'b0, 3'b101, 32'h0000_0026, 32'h0,         32'h0000_1234, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b1, 3'b000, 32'h0000_0025, 32'hFFFF_FF3C, 32'h0,        1'b0, 1'b0, 4'b0010, 32'h3C3C_3C3C);
    do_req(1'b0, 3'b100, 32'h0000_0025, 32'h0,         32'h0000_003C, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0024, 32'h0,         32'h1234_3C78, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0022, 32'h0,         32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 3'b011, 32'h0000_0022, 32'h0,         32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);
    do_req(1'b1, 3'b001, 32'h0000_1001, 32'h0000_1111, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
    do_req(1'b1, 3'b100, 32'h0000_1000, 32'h0000_2222, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);
    do_req(1'b0, 3'b110, 32'h0000_0021, 32'h0,         32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);

    repeat (8) @(negedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);

    // Latency sweep: LW with req_valid held high on all four latency variants.
    @(posedge clk);
    #1 sw_mon = 1'b1; sw_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1 sw_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 sw_mon = 1'b0;
    sw_done = 1'b1;
    @(negedge clk);

    // Reset in the middle of a READ_LATENCY=3 load.
    @(posedge clk);
    #1 sw_valid = 1'b1;
    @(posedge clk);
    #1 sw_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 sw_reset = 1'b1;
    #1;
    check("midrst_ready", 32'(g_sweep[2].ready), 32'd1);
    check("midrst_resp_valid", 32'(g_sweep[2].resp_valid), 32'd0);
    check("midrst_data_en", 32'(g_sweep[2].en), 32'd0);
    check("midrst_outputs", g_sweep[2].rdata | g_sweep[2].wdata |
          {12'h0, g_sweep[2].daddr, g_sweep[2].we}, 32'h0);
    @(posedge clk);
    #1 sw_reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (g_sweep[2].resp_valid) cnt++;
    end
    check("midrst_no_resp", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
